// File: rtl/fbuf_scanout.sv
// fbuf_scanout: display-side scan-out engine for the colour-detect frame buffer.
// Generates VGA timing (640x480@60 by default), walks the frame buffer read
// address across a letterboxed image window and expands RGB565 read data to
// 24-bit RGB, with sync/de/frame_start delayed to line up with the pixel data.
//
// Ports:
//   i_clk          pixel clock
//   i_rstn         synchronous active-low reset
//   i_fbuf_ready   frame buffer holds a complete frame (asynchronous level)
//   o_raddr        frame buffer read address (data returns one cycle later)
//   i_rdata        RGB565 read data
//   o_hsync        horizontal sync, active-low
//   o_vsync        vertical sync, active-low
//   o_de           data enable, high across the active area
//   o_rgb          {R8,G8,B8} pixel
//   o_frame_start  one-cycle pulse with the first active pixel of each frame
module fbuf_scanout #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned IMG_TOP   = 60,
    parameter int unsigned IMG_LINES = 360
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_fbuf_ready,
    output logic [17:0] o_raddr,
    input  logic [15:0] i_rdata,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [23:0] o_rgb,
    output logic        o_frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BRAM_DEPTH = H_ACTIVE * IMG_LINES;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  IMG_FIRST = 10'(IMG_TOP);
    localparam logic [9:0]  IMG_LAST  = 10'(IMG_TOP + IMG_LINES - 1);
    localparam logic [17:0] ADDR_LAST = 18'(BRAM_DEPTH - 1);

    typedef enum logic {
        StWait,
        StScan
    } state_e;

    // Stage 0: timing counters, synchroniser, state, address counter.
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [1:0]  sync_q, sync_d;
    state_e      state_q, state_d;
    logic [17:0] addr_q, addr_d;

    // Stage 1..3 registers; bit 0 is stage 1, bit 2 is stage 3 (the output).
    logic [17:0] raddr_q, raddr_d;
    logic [2:0]  de_q, de_d;
    logic [2:0]  hs_q, hs_d;
    logic [2:0]  vs_q, vs_d;
    logic [2:0]  fs_q, fs_d;
    logic [1:0]  win_q, win_d;
    logic [23:0] rgb_q, rgb_d;

    logic ready_s;
    logic frame_end;
    logic active;
    logic in_img;
    logic win0;
    logic hs0;
    logic vs0;
    logic fs0;

    assign ready_s = sync_q[1];

    always_comb begin
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_img    = (v_cnt_q >= IMG_FIRST) && (v_cnt_q <= IMG_LAST);
        // WAIT suppresses both the address walk and the pixel data.
        win0      = active && in_img && (state_q == StScan);
        hs0       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs0       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        fs0       = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        sync_d = {sync_q[0], i_fbuf_ready};

        // Only enter SCAN on a frame boundary so no partial frame is shown;
        // once scanning, ready dropping is ignored.
        state_d = state_q;
        unique case (state_q)
            StWait:  if (frame_end && ready_s) state_d = StScan;
            StScan:  state_d = StScan;
            default: state_d = StWait;
        endcase

        addr_d = addr_q;
        if (frame_end) begin
            addr_d = 18'd0;
        end else if (win0) begin
            addr_d = (addr_q == ADDR_LAST) ? 18'd0 : addr_q + 18'd1;
        end

        raddr_d = (state_q == StScan) ? addr_q : 18'd0;

        de_d  = {de_q[1:0], active};
        hs_d  = {hs_q[1:0], hs0};
        vs_d  = {vs_q[1:0], vs0};
        fs_d  = {fs_q[1:0], fs0};
        win_d = {win_q[0], win0};

        // i_rdata is valid in stage 2, alongside win_q[1].
        rgb_d = 24'd0;
        if (win_q[1]) begin
            rgb_d = {i_rdata[15:11], i_rdata[15:13],
                     i_rdata[10:5],  i_rdata[10:9],
                     i_rdata[4:0],   i_rdata[4:2]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            sync_q  <= 2'b00;
            state_q <= StWait;
            addr_q  <= 18'd0;
            raddr_q <= 18'd0;
            de_q    <= 3'b000;
            hs_q    <= 3'b111;
            vs_q    <= 3'b111;
            fs_q    <= 3'b000;
            win_q   <= 2'b00;
            rgb_q   <= 24'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            win_q   <= win_d;
            rgb_q   <= rgb_d;
        end
    end

    assign o_raddr       = raddr_q;
    assign o_hsync       = hs_q[2];
    assign o_vsync       = vs_q[2];
    assign o_de          = de_q[2];
    assign o_rgb         = rgb_q;
    assign o_frame_start = fs_q[2];

endmodule

// File: tb/tb_fbuf_scanout.sv
// Bench for fbuf_scanout using a reduced screen geometry so several frames fit
// in a short run. A reference model tracks screen position, ready gating and the
// expected image address; expected outputs are queued per cycle and compared
// when they emerge three cycles later.
module tb_fbuf_scanout;

    localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VA = 12, VFP = 1, VSW = 2, VBP = 2;
    localparam int TOP = 3, LINES = 6;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int DEPTH = HA * LINES;

    logic        i_clk;
    logic        i_rstn;
    logic        i_fbuf_ready;
    logic [17:0] o_raddr;
    logic [15:0] i_rdata;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [23:0] o_rgb;
    logic        o_frame_start;

    fbuf_scanout #(
        .H_ACTIVE  (HA),
        .H_FP      (HFP),
        .H_SYNC    (HSW),
        .H_BP      (HBP),
        .V_ACTIVE  (VA),
        .V_FP      (VFP),
        .V_SYNC    (VSW),
        .V_BP      (VBP),
        .IMG_TOP   (TOP),
        .IMG_LINES (LINES)
    ) u_dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_fbuf_ready  (i_fbuf_ready),
        .o_raddr       (o_raddr),
        .i_rdata       (i_rdata),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_de          (o_de),
        .o_rgb         (o_rgb),
        .o_frame_start (o_frame_start)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Frame buffer model: one-cycle read latency.
    logic [15:0] mem [DEPTH];
    always @(posedge i_clk) begin
        i_rdata <= (o_raddr < 18'(DEPTH)) ? mem[o_raddr[6:0]] : 16'hDEAD;
    end

    typedef struct {
        bit        hs;
        bit        vs;
        bit        de;
        bit        fs;
        bit [23:0] rgb;
        int        addr;
    } exp_t;

    exp_t exp_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_fs = -1;

    int   m_h, m_v, m_addr;
    bit   m_scan, m_s0, m_s1;
    logic [31:0] m_raddr;

    logic [23:0] known_rgb [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit [23:0] expand(input bit [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    function automatic bit in_win(input int h, input int v, input bit sc);
        return sc && h < HA && v < VA && v >= TOP && v < TOP + LINES;
    endfunction

    function automatic exp_t cur_entry();
        exp_t e;
        e.de   = (m_h < HA) && (m_v < VA);
        e.hs   = !(m_h >= HA + HFP && m_h < HA + HFP + HSW);
        e.vs   = !(m_v >= VA + VFP && m_v < VA + VFP + VSW);
        e.fs   = (m_h == 0) && (m_v == 0);
        e.addr = in_win(m_h, m_v, m_scan) ? m_addr : -1;
        e.rgb  = (e.addr >= 0) ? expand(mem[m_addr]) : 24'd0;
        return e;
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.de   = 1'b0;
        e.fs   = 1'b0;
        e.rgb  = 24'd0;
        e.addr = -1;
        return e;
    endfunction

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        exp_t e;
        bit   boundary;
        @(posedge i_clk);
        if (!i_rstn) begin
            m_h = 0; m_v = 0; m_addr = 0;
            m_scan = 0; m_s0 = 0; m_s1 = 0;
            m_raddr = 32'd0;
            last_fs = -1;
            exp_q.delete();
            repeat (3) exp_q.push_back(reset_entry());
            exp_q.push_back(cur_entry());
        end else begin
            m_raddr  = m_scan ? 32'(m_addr) : 32'd0;
            boundary = (m_h == HT - 1) && (m_v == VT - 1);
            if (boundary) m_addr = 0;
            else if (in_win(m_h, m_v, m_scan)) m_addr = (m_addr == DEPTH - 1) ? 0 : m_addr + 1;
            if (!m_scan && boundary && m_s1) m_scan = 1;
            m_s1 = m_s0;
            m_s0 = i_fbuf_ready;
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            exp_q.push_back(cur_entry());
        end
        @(negedge i_clk);
        cyc++;
        if (exp_q.size() == 0) begin
            check_eq("queue", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("hsync", 32'(o_hsync), 32'(e.hs));
            check_eq("vsync", 32'(o_vsync), 32'(e.vs));
            check_eq("de", 32'(o_de), 32'(e.de));
            check_eq("frame_start", 32'(o_frame_start), 32'(e.fs));
            check_eq("rgb", 32'(o_rgb), 32'(e.rgb));
            if (e.addr >= 0 && e.addr < 4) check_eq("colour", 32'(o_rgb), 32'(known_rgb[e.addr]));
        end
        check_eq("raddr", 32'(o_raddr), m_raddr);
        if (o_frame_start) begin
            if (last_fs >= 0) check_eq("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
            last_fs = cyc;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 2 * HT * VT) begin
            step();
            n++;
        end
        check_eq("reach_pos", 32'(m_h == h && m_v == v), 32'd1);
    endtask

    initial begin
        known_rgb[0] = 24'hFF0000;
        known_rgb[1] = 24'h00FF00;
        known_rgb[2] = 24'h0000FF;
        known_rgb[3] = 24'hFFFFFF;
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'(a * 40503) ^ 16'h5A5A;
        mem[0] = 16'hF800;
        mem[1] = 16'h07E0;
        mem[2] = 16'h001F;
        mem[3] = 16'hFFFF;
        mem[4] = 16'h0000;
        mem[DEPTH - 1] = 16'hA5C3;

        i_rstn       = 1'b0;
        i_fbuf_ready = 1'b0;
        repeat (3) step();
        i_rstn = 1'b1;

        // Ready rises mid-image: the rest of this frame stays black.
        run_to(0, 6);
        i_fbuf_ready = 1'b1;
        repeat (2 * HT * VT) step();

        // Ready dropping while scanning is ignored.
        i_fbuf_ready = 1'b0;
        repeat (HT * VT) step();
        i_fbuf_ready = 1'b1;

        // Mid-frame reset, then a fresh WAIT frame before the image returns.
        run_to(10, 8);
        i_rstn = 1'b0;
        repeat (3) step();
        i_rstn = 1'b1;
        repeat (3 * HT * VT) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fbuf_scanout.md
# fbuf_scanout

Display-side scan-out engine for the colour-detect frame buffer. Runs in the pixel-clock domain, generates 640x480@60 VGA timing, drives the frame buffer read address sequentially across a 640x360 letterboxed image window, and converts returned RGB565 words into 24-bit RGB aligned with sync and data-enable. Sits directly downstream of the frame buffer's read port and feeds the display encoder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (total 800)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (total 525)
- IMG_TOP, 60, first active line containing image data
- IMG_LINES, 360, image lines stored in buffer
- BRAM_DEPTH, 230400, frame buffer words (H_ACTIVE*IMG_LINES)
- i_clk  in  1  pixel clock (25 MHz nominal)
- i_rstn  in  1  synchronous, active-low reset
- i_fbuf_ready  in  1  level from write domain; high once first full frame is written; asynchronous to i_clk
- o_raddr  out  18  frame buffer read address
- i_rdata  in  16  RGB565 read data, valid one cycle after o_raddr
- o_hsync  out  1  horizontal sync, active-low
- o_vsync  out  1  vertical sync, active-low
- o_de  out  1  data enable, high in 640x480 active area
- o_rgb  out  24  {R8,G8,B8} pixel
- o_frame_start  out  1  one-cycle pulse aligned with first active pixel of each frame

## Operation
- Counters: h_cnt 0..799, v_cnt 0..524; h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 after 524. Active area h_cnt<640 and v_cnt<480.
- Sync: hsync low for h_cnt in [656,751]; vsync low for v_cnt in [490,491].
- Image window: active area AND v_cnt in [IMG_TOP, IMG_TOP+IMG_LINES-1] = [60,419]. Outside window but inside active area, o_rgb = 0 (black) with o_de high.
- i_fbuf_ready passes through a 2-flop synchroniser before use.
- State machine, two states:
  - WAIT: o_rgb forced 0; o_raddr held 0. Transition to SCAN only at h_cnt==799 && v_cnt==524 (frame boundary) when synchronised ready is high.
  - SCAN: normal scan-out. Stays in SCAN once entered; de-assertion of ready is ignored (buffer continuously overwritten).
- Address: read address counter reset to 0 at frame boundary; incremented by 1 on each in-window pixel cycle; o_raddr presents current counter. After the last window pixel the counter is BRAM_DEPTH-1+1 and is forced to 0 (never exceeds BRAM_DEPTH-1 on o_raddr).
- Colour expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; 0xFFFF -> 0xFFFFFF, 0x0000 -> 0x000000, 0xF800 -> 0xFF0000.

## Timing
- Pipeline: stage 0 counters; stage 1 o_raddr registered; stage 2 i_rdata valid; stage 3 o_rgb registered. o_hsync, o_vsync, o_de, window flag and o_frame_start delayed through matching 3-cycle shift so all outputs are mutually aligned.
- Total latency from counter position (h,v) to corresponding outputs: 3 cycles.
- o_frame_start high for exactly one cycle, coincident with o_de of pixel (0,0), every frame including during WAIT.
- Reset values (i_rstn low at a clock edge): h_cnt=0, v_cnt=0, state WAIT, synchroniser 0, o_raddr=0, o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_frame_start=0, all delay-pipe stages cleared.
- Reset mid-frame: outputs take reset values on next edge; scanning restarts from (0,0) in WAIT; first image frame requires a full frame boundary with ready high.
- Ready rising mid-frame: no partial frame displayed; image appears from next frame's pixel (0,IMG_TOP).
- Address sequence per frame in SCAN: 0,1,...,230399 exactly once; no gaps, no repeats.

## Test plan
- Timing: run 2 frames after reset -> hsync period 800 cycles, low width 96; vsync low 2 lines (1600 cycles); o_de high 640x480 cycles per frame; frame_start period 420000 cycles.
- Ready gating: raise i_fbuf_ready at v_cnt=200 -> o_rgb stays 0 rest of frame; first nonzero-eligible pixel at next frame line 60, o_raddr=0 there.
- Address/data: BRAM model returns rdata=addr[15:0] one cycle later -> at pixel (x,60+y) o_rgb equals expansion of (640*y+x)[15:0]; last in-window address 230399, then 0; no skipped addresses.
- Letterbox: in SCAN, lines 0-59 and 420-479 -> o_de=1, o_rgb=0x000000; o_raddr does not advance.
- Colour expansion: rdata 0xF800, 0x07E0, 0x001F, 0xFFFF -> o_rgb 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF.
- Mid-frame reset: assert i_rstn=0 at (300,250) for 3 cycles -> outputs at reset values; after release h/v restart at 0, state WAIT, frame_start at latency 3.
